// File: rtl/windowed_repetition.sv
// Counts distinct field values seen at least THRESHOLD times per window of WINDOW_SIZE valid samples.
// Optional macro REP_DISTINCT_EN adds distinct_rate, the distinct-value count of the last window.
module windowed_repetition #(
    parameter int FIELD_SIZE      = 16,
    parameter int WINDOW_SIZE     = 32,
    parameter int THRESHOLD       = 2,
    parameter int FOUND_THRESHOLD = 1,
    parameter int TAG_W           = 4,
    localparam int CNT_W   = $clog2(THRESHOLD + 1),
    localparam int COUNT_W = $clog2(WINDOW_SIZE + 1),
    localparam int WC_W    = $clog2(WINDOW_SIZE)
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [FIELD_SIZE-1:0] field,
    output logic [COUNT_W-1:0]    rep_count,
    output logic [COUNT_W-1:0]    rep_rate,
    output logic                  rate_valid,
    output logic                  found
`ifdef REP_DISTINCT_EN
    ,
    output logic [COUNT_W-1:0]    distinct_rate
`endif
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [CNT_W-1:0] cnt;
    } word_t;

    localparam logic [CNT_W-1:0] THR   = CNT_W'(THRESHOLD);
    localparam logic [CNT_W:0]   THR_X = (CNT_W + 1)'(THRESHOLD);

    // Not reset: tags make stale entries harmless, so zero init only matters for tag 0.
    word_t mem [2**FIELD_SIZE] = '{default: '0};

    logic [WC_W-1:0]       window_count;
    logic [TAG_W-1:0]      win_id;
    logic                  win_end;

    logic                  s0_valid, s0_last;
    logic [FIELD_SIZE-1:0] s0_field;
    logic [TAG_W-1:0]      s0_tag;

    logic                  s1_valid, s1_last;
    logic [FIELD_SIZE-1:0] s1_field;
    logic [TAG_W-1:0]      s1_tag;
    word_t                 rd_word;

    logic                  s2_valid, s2_last, s2_event;
    logic [FIELD_SIZE-1:0] s2_field;
    word_t                 s2_word;

    word_t                 cur_word, new_word;
    logic [CNT_W-1:0]      old_cnt, new_cnt;
    logic [CNT_W:0]        inc_cnt;
    logic                  hit_event, wr_en, close;

    assign win_end = (window_count == WC_W'(WINDOW_SIZE - 1));
    assign wr_en   = s1_valid & ~clear;
    assign close   = s2_valid & s2_last & ~clear;

    // S2 holds the word written on the previous edge; the RAM read on that edge missed it.
    always_comb begin
        cur_word = rd_word;
        if (s2_valid && (s2_field == s1_field))
            cur_word = s2_word;
        old_cnt = (cur_word.tag == s1_tag) ? cur_word.cnt : '0;
        inc_cnt = {1'b0, old_cnt} + 1'b1;
        new_cnt = (inc_cnt >= THR_X) ? THR : inc_cnt[CNT_W-1:0];
        hit_event = (old_cnt < THR) && (new_cnt == THR);
        new_word.tag = s1_tag;
        new_word.cnt = new_cnt;
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem[s1_field] <= new_word;
        rd_word <= mem[s0_field];
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            window_count <= '0;
            win_id       <= TAG_W'(1);
            s0_valid     <= 1'b0;
            s0_last      <= 1'b0;
            s0_field     <= '0;
            s0_tag       <= '0;
            s1_valid     <= 1'b0;
            s1_last      <= 1'b0;
            s1_field     <= '0;
            s1_tag       <= '0;
            s2_valid     <= 1'b0;
            s2_last      <= 1'b0;
            s2_event     <= 1'b0;
            s2_field     <= '0;
            s2_word      <= '0;
        end else begin
            s0_valid <= valid & ~clear;
            s0_last  <= valid & ~clear & win_end;
            s0_field <= field;
            s0_tag   <= win_id;
            s1_valid <= s0_valid & ~clear;
            s1_last  <= s0_last;
            s1_field <= s0_field;
            s1_tag   <= s0_tag;
            s2_valid <= s1_valid & ~clear;
            s2_last  <= s1_last;
            s2_event <= hit_event;
            s2_field <= s1_field;
            s2_word  <= new_word;
            if (clear) begin
                window_count <= '0;
                win_id       <= win_id + 1'b1;
            end else if (valid) begin
                window_count <= window_count + 1'b1;
                if (win_end)
                    win_id <= win_id + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_count  <= '0;
            rep_rate   <= '0;
            rate_valid <= 1'b0;
            found      <= 1'b0;
        end else begin
            rate_valid <= close;
            found      <= (rep_rate >= COUNT_W'(FOUND_THRESHOLD));
            if (clear) begin
                rep_count <= '0;
            end else if (close) begin
                rep_rate  <= rep_count + COUNT_W'(s2_event);
                rep_count <= '0;
            end else if (s2_valid && s2_event) begin
                rep_count <= rep_count + 1'b1;
            end
        end
    end

`ifdef REP_DISTINCT_EN
    logic                s2_fresh;
    logic [COUNT_W-1:0]  dist_count;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_fresh      <= 1'b0;
            dist_count    <= '0;
            distinct_rate <= '0;
        end else begin
            s2_fresh <= (old_cnt == '0);
            if (clear) begin
                dist_count <= '0;
            end else if (close) begin
                distinct_rate <= dist_count + COUNT_W'(s2_fresh);
                dist_count    <= '0;
            end else if (s2_valid && s2_fresh) begin
                dist_count <= dist_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_windowed_repetition.sv
// Directed bench for windowed_repetition with an 8-sample window, threshold 2 and 4-bit fields.
module tb_windowed_repetition;

    localparam int FS = 4;
    localparam int CW = 4;

    logic          sys_clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          valid;
    logic [FS-1:0] field;
    logic [CW-1:0] rep_count;
    logic [CW-1:0] rep_rate;
    logic          rate_valid;
    logic          found;
`ifdef REP_DISTINCT_EN
    logic [CW-1:0] distinct_rate;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;

    windowed_repetition #(
        .FIELD_SIZE(FS), .WINDOW_SIZE(8), .THRESHOLD(2), .FOUND_THRESHOLD(1), .TAG_W(4)
    ) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .clear(clear), .valid(valid), .field(field),
        .rep_count(rep_count), .rep_rate(rep_rate), .rate_valid(rate_valid), .found(found)
`ifdef REP_DISTINCT_EN
        , .distinct_rate(distinct_rate)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [FS-1:0] f);
        valid = v;
        field = f;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0);
    endtask

    // Eight back-to-back samples, most significant nibble first.
    task automatic burst(input logic [31:0] v);
        for (int i = 7; i >= 0; i--) tick(1'b1, v[i*4 +: 4]);
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        valid   = 1'b0;
        field   = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_rep_count", rep_count, 0);
        check("rst_rep_rate", rep_rate, 0);
        check("rst_rate_valid", rate_valid, 0);
        check("rst_found", found, 0);
        reset_n = 1'b1;

        // window tag 1: 5,5,7,9,7,7,1,2
        tick(1, 5); tick(1, 5); tick(1, 7); tick(1, 9); tick(1, 7);
        check("t1_live_first", rep_count, 1);
        tick(1, 7); tick(1, 1); tick(1, 2);
        check("t1_live_end", rep_count, 2);
        idle(2);
        check("t1_no_early_pulse", rate_valid, 0);
        idle(1);
        check("t1_pulse", rate_valid, 1);
        check("t1_rep_rate", rep_rate, 2);
        check("t1_count_cleared", rep_count, 0);
        check("t1_found_late", found, 0);
        idle(1);
        check("t1_pulse_single", rate_valid, 0);
        check("t1_found", found, 1);

        // window tag 2: forwarding and saturation
        burst(32'h3333_4568);
        idle(3);
        check("t2_pulse", rate_valid, 1);
        check("t2_rep_rate", rep_rate, 1);
`ifdef REP_DISTINCT_EN
        check("t2_distinct", distinct_rate, 5);
`endif
        idle(1);
        check("t2_found", found, 1);

        // window tag 3: 4,idle,4 then 11,6,11
        tick(1, 4); tick(0, 0); tick(1, 4); tick(1, 11); tick(1, 6);
        check("t3_before_latency", rep_count, 0);
        tick(1, 11);
        check("t3_after_latency", rep_count, 1);
        tick(1, 12); tick(1, 13); tick(1, 14);
        check("t3_second_pair", rep_count, 2);
        idle(3);
        check("t3_pulse", rate_valid, 1);
        check("t3_rep_rate", rep_rate, 2);

        // clear after 2,2,9; a valid in the clear cycle is dropped
        tick(1, 2); tick(1, 2); tick(1, 9);
        clear = 1'b1;
        tick(1, 2);
        clear = 1'b0;
        check("t5_count_cleared", rep_count, 0);
        idle(3);
        check("t5_no_event", rep_count, 0);
        check("t5_no_pulse", rate_valid, 0);
        check("t5_rate_held", rep_rate, 2);
        check("t5_found_held", found, 1);
        burst(32'h2921_380F);
        check("t5_window_aligned", rep_count, 1);
        idle(2);
        check("t5_no_early_pulse", rate_valid, 0);
        idle(1);
        check("t5_pulse", rate_valid, 1);
        check("t5_rep_rate", rep_rate, 1);

        // 5 closes one window and opens the next
        burst(32'hFEDC_BA75);
        tick(1, 5); tick(1, 0); tick(1, 1);
        check("t4_pulse_a", rate_valid, 1);
        check("t4_rate_a", rep_rate, 0);
        tick(1, 3);
        check("t4_found_low", found, 0);
        tick(1, 4); tick(1, 6); tick(1, 8); tick(1, 9);
        idle(3);
        check("t4_pulse_b", rate_valid, 1);
        check("t4_rate_b", rep_rate, 0);

        // full window, then reset in the middle of the next one
        burst(32'h1122_3456);
        idle(3);
        check("t6_rep_rate", rep_rate, 2);
        idle(1);
        check("t6_found", found, 1);
        tick(1, 7); tick(1, 7); tick(1, 8); tick(1, 0); tick(1, 10);
        check("t6_live_before_reset", rep_count, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_async_rep_count", rep_count, 0);
        check("t6_async_rep_rate", rep_rate, 0);
        check("t6_async_found", found, 0);
        check("t6_async_rate_valid", rate_valid, 0);
        valid = 1'b0;
        @(posedge sys_clk);
        #1;
        reset_n = 1'b1;
        burst(32'h00AA_ACDE);
        idle(3);
        check("t6_post_pulse", rate_valid, 1);
        check("t6_post_rate", rep_rate, 2);
        idle(1);
        check("t6_post_found", found, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
